// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-port 256-word unified memory between the
// instruction-fetch requester and the load/store requester.
//
// Requests use a hold-until-ack handshake: a requester raises x_req with its
// address (and write data), keeps them stable while it waits, and gets a
// one-cycle x_ack. x_rdata is valid in the x_ack cycle and holds until the
// next x_ack.
//
// Optional feature: define MEMARB_DATA_PRIO_EN to make data win every tie.
// Without it, ties alternate between the requesters (round-robin).
module mem_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  conflict_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;       // 0 = fetch granted last, 1 = data
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               we_q, we_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               if_ack_q, if_ack_d;
    logic               d_ack_q, d_ack_d;
    logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               i_elig;
    logic               d_elig;
    logic               tie;
    logic               grant_i;
    logic               grant_d;

    // Eligibility masking, arbitration, request latching and response capture.
    // A requester is never eligible in its own SERVE cycle or its ack cycle, so
    // a held request is not served twice and the other side always gets a turn.
    always_comb begin
        state_d    = IDLE;
        last_d     = last_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        cnt_d      = cnt_q;

        i_elig = if_req && (state_q != SERVE_I) && !if_ack_q;
        d_elig = d_req  && (state_q != SERVE_D) && !d_ack_q;
        tie    = i_elig && d_elig;

`ifdef MEMARB_DATA_PRIO_EN
        grant_d = d_elig;
`else
        grant_d = d_elig && (!i_elig || !last_q);
`endif
        grant_i = i_elig && !grant_d;

        if (grant_d) begin
            state_d = SERVE_D;
            last_d  = 1'b1;
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
        end else if (grant_i) begin
            state_d = SERVE_I;
            last_d  = 1'b0;
            addr_d  = if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
        end

        // The memory read is asynchronous, so the word is sampled at the end of
        // the SERVE cycle; for a store this is the pre-write contents.
        if_ack_d = (state_q == SERVE_I);
        d_ack_d  = (state_q == SERVE_D);
        if (state_q == SERVE_I) begin
            if_rdata_d = mem_rdata;
        end
        if (state_q == SERVE_D) begin
            d_rdata_d = mem_rdata;
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (tie && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // All state and registered outputs; reset drops mem_we without a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_we       = (state_q == SERVE_D) && we_q;
    assign busy         = (state_q != IDLE);
    assign if_ack       = if_ack_q;
    assign d_ack        = d_ack_q;
    assign if_rdata     = if_rdata_q;
    assign d_rdata      = d_rdata_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a transaction-level
// model. Honors MEMARB_DATA_PRIO_EN the same way as the design.
module tb_mem_port_arbiter;

    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] conflict_cnt;

    int total = 0;
    int bad   = 0;

    // Clock and reset block.
    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy),
        .cnt_clr(cnt_clr), .conflict_cnt(conflict_cnt)
    );

    // Memory the DUT drives: asynchronous read, write on the rising edge.
    logic [DW-1:0] tb_mem [256];
    assign mem_rdata = tb_mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    end

    // Transaction-level model: who is being served, pending acks, the last
    // winner for ties, and a shadow copy of the memory.
    int            m_serv = 0;           // 0 none, 1 fetch, 2 data
    logic [AW-1:0] m_addr = '0;
    logic          m_we = 1'b0;
    logic [DW-1:0] m_wdata = '0;
    logic          m_last_d = 1'b0;
    logic          m_if_ack = 1'b0;
    logic          m_d_ack = 1'b0;
    logic [DW-1:0] m_if_rdata = '0;
    logic [DW-1:0] m_d_rdata = '0;
    int            m_cnt = 0;
    logic [DW-1:0] m_mem [256];
    logic          i_ok, d_ok, pick_d;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_serv = 0; m_addr = '0; m_we = 1'b0; m_wdata = '0; m_last_d = 1'b0;
            m_if_ack = 1'b0; m_d_ack = 1'b0; m_if_rdata = '0; m_d_rdata = '0;
            m_cnt = 0;
        end else begin
            i_ok = if_req && (m_serv != 1) && !m_if_ack;
            d_ok = d_req  && (m_serv != 2) && !m_d_ack;
            m_if_ack = (m_serv == 1);
            m_d_ack  = (m_serv == 2);
            if (m_serv == 1) m_if_rdata = m_mem[m_addr];
            if (m_serv == 2) begin
                m_d_rdata = m_mem[m_addr];
                if (m_we) m_mem[m_addr] = m_wdata;
            end
            if (cnt_clr) m_cnt = 0;
            else if (i_ok && d_ok && m_cnt < CMAX) m_cnt = m_cnt + 1;
            if (i_ok && d_ok) begin
`ifdef MEMARB_DATA_PRIO_EN
                pick_d = 1'b1;
`else
                pick_d = !m_last_d;
`endif
            end else begin
                pick_d = d_ok;
            end
            if (pick_d) begin
                m_serv = 2; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata; m_last_d = 1'b1;
            end else if (i_ok) begin
                m_serv = 1; m_addr = if_addr; m_we = 1'b0; m_last_d = 1'b0;
            end else begin
                m_serv = 0;
            end
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard compare: every cycle out of reset, DUT against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("if_ack", 32'(if_ack), 32'(m_if_ack));
            check("d_ack", 32'(d_ack), 32'(m_d_ack));
            check("if_rdata", if_rdata, m_if_rdata);
            check("d_rdata", d_rdata, m_d_rdata);
            check("busy", 32'(busy), 32'(m_serv != 0));
            check("mem_we", 32'(mem_we), 32'((m_serv == 2) && m_we));
            check("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
            if (m_serv != 0) check("mem_addr", 32'(mem_addr), 32'(m_addr));
            if (m_serv == 2 && m_we) check("mem_wdata", mem_wdata, m_wdata);
        end
    end

    // Driver tasks.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; cnt_clr = 1'b0;
        for (int k = 0; k < n; k++) cyc();
    endtask

    logic [DW-1:0] saved;
    int            n_iack, n_dack;
    bit            i_pend, d_pend;

    initial begin
        for (int a = 0; a < 256; a++) begin
            tb_mem[a] = $urandom;
            m_mem[a]  = tb_mem[a];
        end
        tb_mem[5]    = 32'h8C01_0004; m_mem[5]    = 32'h8C01_0004;
        tb_mem[8'h30] = 32'h0BAD_F00D; m_mem[8'h30] = 32'h0BAD_F00D;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset if_ack", 32'(if_ack), 32'd0);
        check("reset d_ack", 32'(d_ack), 32'd0);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset cnt", 32'(conflict_cnt), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        cyc();
        rst = 1'b0;

        // Single fetch from IDLE: SERVE in the next cycle, ack the one after.
        if_req = 1'b1; if_addr = 8'h05;
        cyc();
        check("t1 busy serve", 32'(busy), 32'd1);
        check("t1 mem_addr", 32'(mem_addr), 32'h05);
        cyc();
        check("t1 if_ack", 32'(if_ack), 32'd1);
        check("t1 if_rdata", if_rdata, 32'h8C01_0004);
        if_req = 1'b0;
        cyc();
        check("t1 busy after", 32'(busy), 32'd0);
        check("t1 ack pulse", 32'(if_ack), 32'd0);

        // Store then load of the same address.
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 32'hDEAD_BEEF;
        cyc();
        check("t2 mem_we on", 32'(mem_we), 32'd1);
        check("t2 mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        cyc();
        check("t2 mem_we off", 32'(mem_we), 32'd0);
        check("t2 store ack", 32'(d_ack), 32'd1);
        d_we = 1'b0;
        cyc();
        check("t2 masked idle", 32'(busy), 32'd0);
        cyc();
        check("t2 load no write", 32'(mem_we), 32'd0);
        check("t2 load serve", 32'(busy), 32'd1);
        cyc();
        check("t2 load ack", 32'(d_ack), 32'd1);
        check("t2 load data", d_rdata, 32'hDEAD_BEEF);
        idle_cycles(2);

        // Reset in the middle of a store's SERVE cycle.
        saved = tb_mem[8'h30];
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h30; d_wdata = 32'h1234_5678;
        @(posedge clk);
        #2;
        check("t5 mem_we before", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1;
        check("t5 mem_we async", 32'(mem_we), 32'd0);
        check("t5 busy async", 32'(busy), 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t5 mem unchanged", tb_mem[8'h30], saved);
        check("t5 no d_ack", 32'(d_ack), 32'd0);
        check("t5 d_rdata reset", d_rdata, 32'd0);
        check("t5 if_rdata reset", if_rdata, 32'd0);
        cyc();
        rst = 1'b0;

        // Simultaneous requests straight after reset: data wins the tie.
        if_req = 1'b1; if_addr = 8'h05;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
        cyc();
        check("t3 data first", 32'(mem_addr), 32'h20);
        check("t3 conflict", 32'(conflict_cnt), 32'd1);
        cyc();
        check("t3 fetch second", 32'(mem_addr), 32'h05);
        check("t3 d_ack", 32'(d_ack), 32'd1);
        check("t3 d_rdata", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        cyc();
        check("t3 if_ack", 32'(if_ack), 32'd1);
        check("t3 if_rdata", if_rdata, 32'h8C01_0004);
        idle_cycles(3);

        // Both requesters held for 20 cycles: neither side starves.
        n_iack = 0; n_dack = 0;
        if_req = 1'b1; if_addr = 8'h03;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h04;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (if_ack) n_iack++;
            if (d_ack) n_dack++;
        end
        check("hold fetch served", 32'(n_iack >= 6), 32'd1);
        check("hold data served", 32'(n_dack >= 6), 32'd1);
        idle_cycles(3);

        // Saturate the conflict counter, then clear it.
        for (int k = 0; k < CMAX + 4; k++) begin
            if_req = 1'b1; if_addr = 8'(k);
            d_req = 1'b1; d_we = 1'b0; d_addr = 8'(k + 1);
            cyc();
            cyc();
            if_req = 1'b0; d_req = 1'b0;
            cyc();
            cyc();
        end
        check("cnt saturated", 32'(conflict_cnt), 32'(CMAX));
        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        check("cnt cleared", 32'(conflict_cnt), 32'd0);
        idle_cycles(2);

        // Randomized traffic with hold-until-ack requesters.
        i_pend = 1'b0; d_pend = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            if (i_pend && if_ack) i_pend = 1'b0;
            if (d_pend && d_ack) d_pend = 1'b0;
            if (!i_pend && $urandom_range(0, 99) < 60) begin
                i_pend = 1'b1;
                if_addr = 8'($urandom_range(0, 15));
            end
            if (!d_pend && $urandom_range(0, 99) < 60) begin
                d_pend = 1'b1;
                d_we = 1'($urandom_range(0, 1));
                d_addr = 8'($urandom_range(0, 15));
                d_wdata = $urandom;
            end
            if_req = i_pend;
            d_req = d_pend;
            cnt_clr = ($urandom_range(0, 63) == 0);
            cyc();
        end
        idle_cycles(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
